seg_scan_mux: RTL and testbench

Parametrised, time-multiplexed digit selector for the seven-segment display path. It takes CHANNELS digit values of WIDTH bits and presents one value at a time to the shared decoder, together with a one-hot digit-enable. In auto mode it scans the digits from a built-in refresh prescaler; in manual mode an external select picks the digit, which replaces the plain 2:1 set select. A guard interval blanks all digit enables after every digit change to prevent ghosting. Per-channel blanking is provided.

---
 rtl/seg_scan_mux_if.sv | 30 +++
 rtl/seg_scan_mux.sv | 102 ++++++++++
 tb/tb_seg_scan_mux.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_mux_if.sv
// Bus bundle between the digit sources and the seven-segment scan multiplexer.
interface seg_scan_mux_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 4
);
    localparam int unsigned IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [CHANNELS-1:0]       blank_in;
    logic                      mode;
    logic                      enable;
    logic [IDXW-1:0]           sel_in;
    logic [WIDTH-1:0]          digit_out;
    logic [CHANNELS-1:0]       digit_sel;
    logic [IDXW-1:0]           digit_idx;
    logic                      blank_out;
    logic                      scan_tick;

    // Source side: supplies digits and control, observes the display path.
    modport master (
        output data_in, blank_in, mode, enable, sel_in,
        input  digit_out, digit_sel, digit_idx, blank_out, scan_tick
    );

    // Multiplexer side.
    modport slave (
        input  data_in, blank_in, mode, enable, sel_in,
        output digit_out, digit_sel, digit_idx, blank_out, scan_tick
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed digit selector: auto scan from a refresh prescaler or manual
// select, with a dark guard interval after each digit change and per-channel blanking.
module seg_scan_mux #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DIV      = 50000,
    parameter int unsigned GUARD    = 2
) (
    input  logic          clk,
    input  logic          reset,
    seg_scan_mux_if.slave bus
);
    localparam int unsigned IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned PREW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned GCW  = $clog2(GUARD + 1);

    logic [PREW-1:0]     pre_q,   pre_d;
    logic [IDXW-1:0]     idx_q,   idx_d;
    logic [GCW-1:0]      gc_q,    gc_d;
    logic [WIDTH-1:0]    out_q,   out_d;
    logic [CHANNELS-1:0] sel_q,   sel_d;
    logic                blank_q, blank_d;
    logic                tick_q,  tick_d;

    logic [WIDTH-1:0]    cur_data_c;
    logic                cur_blank_c;
    logic [CHANNELS-1:0] onehot_c;
    logic                lit_c;

    // Current-channel view: data, blank flag and one-hot enable for idx_q.
    always_comb begin
        cur_data_c  = '0;
        cur_blank_c = 1'b0;
        onehot_c    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (idx_q == IDXW'(i)) begin
                cur_data_c  = bus.data_in[i*WIDTH +: WIDTH];
                cur_blank_c = bus.blank_in[i];
                onehot_c[i] = 1'b1;
            end
        end
        lit_c = (gc_q == '0) && !cur_blank_c;
    end

    // Next-state: prescaler/index stepping, manual select, guard countdown, outputs.
    always_comb begin
        pre_d   = pre_q;
        idx_d   = idx_q;
        tick_d  = 1'b0;
        gc_d    = (gc_q != '0) ? gc_q - GCW'(1) : gc_q;
        out_d   = cur_blank_c ? '0 : cur_data_c;
        sel_d   = lit_c ? onehot_c : '0;
        blank_d = !lit_c;

        if (!bus.mode) begin
            if (bus.enable) begin
                if (pre_q == PREW'(DIV - 1)) begin
                    pre_d  = '0;
                    idx_d  = (idx_q == IDXW'(CHANNELS - 1)) ? '0 : idx_q + IDXW'(1);
                    gc_d   = GCW'(GUARD);
                    tick_d = 1'b1;
                end else begin
                    pre_d = pre_q + PREW'(1);
                end
            end
        end else begin
            // Manual select overrides any pending terminal count; out-of-range selects are ignored.
            pre_d = '0;
            if ((32'(bus.sel_in) < CHANNELS) && (bus.sel_in != idx_q)) begin
                idx_d = bus.sel_in;
                gc_d  = GCW'(GUARD);
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q   <= '0;
            idx_q   <= '0;
            gc_q    <= GCW'(GUARD);
            out_q   <= '0;
            sel_q   <= '0;
            blank_q <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            gc_q    <= gc_d;
            out_q   <= out_d;
            sel_q   <= sel_d;
            blank_q <= blank_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.digit_out = out_q;
    assign bus.digit_sel = sel_q;
    assign bus.digit_idx = idx_q;
    assign bus.blank_out = blank_q;
    assign bus.scan_tick = tick_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: a 4-channel and a 3-channel instance share stimulus and
// are compared every cycle against an event-level model, plus pinned literal checks.
module tb_seg_scan_mux;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned DIV   = 6;
    localparam int unsigned GUARD = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic [3:0]  blank_in;
    logic        mode;
    logic        enable;
    logic [1:0]  sel_in;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seg_scan_mux_if #(.CHANNELS(4), .WIDTH(WIDTH)) bus4 ();
    seg_scan_mux_if #(.CHANNELS(3), .WIDTH(WIDTH)) bus3 ();

    assign bus4.data_in  = data_in;
    assign bus4.blank_in = blank_in;
    assign bus4.mode     = mode;
    assign bus4.enable   = enable;
    assign bus4.sel_in   = sel_in;
    assign bus3.data_in  = data_in[11:0];
    assign bus3.blank_in = blank_in[2:0];
    assign bus3.mode     = mode;
    assign bus3.enable   = enable;
    assign bus3.sel_in   = sel_in;

    seg_scan_mux #(.CHANNELS(4), .WIDTH(WIDTH), .DIV(DIV), .GUARD(GUARD)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    seg_scan_mux #(.CHANNELS(3), .WIDTH(WIDTH), .DIV(DIV), .GUARD(GUARD)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Event-level model: tracks the displayed channel, cycles spent in the current
    // scan slot and the edge of the most recent channel change. A channel is dark
    // until more than GUARD edges have passed since it was selected.
    int m_chan [2] = '{4, 3};
    int m_idx  [2];
    int m_pre  [2];
    int m_last [2];
    int e_out  [2];
    int e_sel  [2];
    int e_blank[2];
    int e_tick [2];
    int e_idx  [2];
    int edge_n = 0;
    bit m_valid = 1'b0;
    bit m_dark;

    always @(posedge clk) begin
        edge_n++;
        for (int n = 0; n < 2; n++) begin
            if (reset) begin
                m_idx[n]   = 0;
                m_pre[n]   = 0;
                m_last[n]  = edge_n;
                e_out[n]   = 0;
                e_sel[n]   = 0;
                e_blank[n] = 1;
                e_tick[n]  = 0;
            end else begin
                m_dark     = ((edge_n - 1 - m_last[n]) < int'(GUARD)) || blank_in[m_idx[n]];
                e_out[n]   = blank_in[m_idx[n]] ? 0 : int'((data_in >> (4 * m_idx[n])) & 16'hF);
                e_sel[n]   = m_dark ? 0 : (1 << m_idx[n]);
                e_blank[n] = m_dark ? 1 : 0;
                e_tick[n]  = 0;
                if (!mode) begin
                    if (enable) begin
                        m_pre[n]++;
                        if (m_pre[n] == int'(DIV)) begin
                            m_pre[n]  = 0;
                            m_idx[n]  = (m_idx[n] + 1) % m_chan[n];
                            m_last[n] = edge_n;
                            e_tick[n] = 1;
                        end
                    end
                end else begin
                    m_pre[n] = 0;
                    if (int'(sel_in) < m_chan[n] && int'(sel_in) != m_idx[n]) begin
                        m_idx[n]  = int'(sel_in);
                        m_last[n] = edge_n;
                    end
                end
            end
            e_idx[n] = m_idx[n];
        end
        if (reset) m_valid = 1'b1;
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("c4_digit_out", int'(bus4.digit_out), e_out[0]);
            check("c4_digit_sel", int'(bus4.digit_sel), e_sel[0]);
            check("c4_digit_idx", int'(bus4.digit_idx), e_idx[0]);
            check("c4_blank_out", int'(bus4.blank_out), e_blank[0]);
            check("c4_scan_tick", int'(bus4.scan_tick), e_tick[0]);
            check("c3_digit_out", int'(bus3.digit_out), e_out[1]);
            check("c3_digit_sel", int'(bus3.digit_sel), e_sel[1]);
            check("c3_digit_idx", int'(bus3.digit_idx), e_idx[1]);
            check("c3_blank_out", int'(bus3.blank_out), e_blank[1]);
            check("c3_scan_tick", int'(bus3.scan_tick), e_tick[1]);
        end
    end

    int exp3;

    initial begin
        reset    = 1'b1;
        data_in  = 16'h4321;
        blank_in = 4'b0000;
        mode     = 1'b0;
        enable   = 1'b1;
        sel_in   = 2'd0;
        step(3);
        check("rst_sel", int'(bus4.digit_sel), 0);
        check("rst_blank", int'(bus4.blank_out), 1);
        reset = 1'b0;

        // Reset release: two dark cycles, channel 0 lights, first advance at 6 cycles.
        step(1);
        check("rel1_sel", int'(bus4.digit_sel), 0);
        step(1);
        check("rel2_sel", int'(bus4.digit_sel), 1);
        check("rel2_out", int'(bus4.digit_out), 1);
        step(4);
        check("adv1_idx", int'(bus4.digit_idx), 1);
        check("adv1_tick", int'(bus4.scan_tick), 1);
        check("adv1_sel_old", int'(bus4.digit_sel), 1);
        step(1);
        check("adv1_dark_sel", int'(bus4.digit_sel), 0);
        check("adv1_dark_out", int'(bus4.digit_out), 2);
        check("adv1_tick_gone", int'(bus4.scan_tick), 0);
        step(1);
        check("adv1_lit_sel", int'(bus4.digit_sel), 2);
        check("adv1_lit_out", int'(bus4.digit_out), 2);
        step(18);

        // Enable freeze: hold the prescaler at 3, then advance on the third enabled edge.
        for (int k = 0; k < 20 && m_pre[0] != 3; k++) step(1);
        if (m_pre[0] != 3) check("freeze_reach_pre3", m_pre[0], 3);
        enable = 1'b0;
        step(10);
        enable = 1'b1;
        step(2);
        check("reen_tick_e2", int'(bus4.scan_tick), 0);
        step(1);
        check("reen_tick_e3", int'(bus4.scan_tick), 1);

        // Blanking of channel 2: the slot stays dark but still runs its full length.
        blank_in = 4'b0100;
        for (int k = 0; k < 40 && e_idx[0] != 2; k++) step(1);
        if (e_idx[0] != 2) check("blank_reach_idx2", e_idx[0], 2);
        step(3);
        check("blank_sel", int'(bus4.digit_sel), 0);
        check("blank_out_val", int'(bus4.digit_out), 0);
        check("blank_flag", int'(bus4.blank_out), 1);
        step(12);
        blank_in = 4'b0000;

        // Manual select of channel 3; the 3-channel instance ignores it.
        mode   = 1'b1;
        sel_in = 2'd3;
        exp3   = e_idx[1];
        step(1);
        check("man_idx4", int'(bus4.digit_idx), 3);
        check("man_idx3_hold", int'(bus3.digit_idx), exp3);
        step(1);
        check("man_dark_sel", int'(bus4.digit_sel), 0);
        step(1);
        check("man_lit_sel", int'(bus4.digit_sel), 8);
        check("man_lit_out", int'(bus4.digit_out), 4);
        check("man_no_tick", int'(bus4.scan_tick), 0);
        step(8);
        check("man_steady_sel", int'(bus4.digit_sel), 8);

        // Randomized traffic, including occasional resets.
        for (int k = 0; k < 700; k++) begin
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            if ($urandom_range(0, 9) == 0) enable = ~enable;
            if ($urandom_range(0, 7) == 0) sel_in = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) blank_in = 4'($urandom);
            if ($urandom_range(0, 3) == 0) data_in = 16'($urandom);
            reset = ($urandom_range(0, 99) == 0);
            step(1);
        end

        // Reset immediately after an auto-mode index change.
        reset    = 1'b0;
        mode     = 1'b0;
        enable   = 1'b1;
        blank_in = 4'b0000;
        data_in  = 16'h4321;
        for (int k = 0; k < 30 && e_tick[0] != 1; k++) step(1);
        if (e_tick[0] != 1) check("midguard_reach_tick", e_tick[0], 1);
        reset = 1'b1;
        step(1);
        check("mg_idx", int'(bus4.digit_idx), 0);
        check("mg_sel", int'(bus4.digit_sel), 0);
        check("mg_out", int'(bus4.digit_out), 0);
        check("mg_blank", int'(bus4.blank_out), 1);
        check("mg_tick", int'(bus4.scan_tick), 0);
        reset = 1'b0;
        step(1);
        check("mg_rel1_sel", int'(bus4.digit_sel), 0);
        step(1);
        check("mg_rel2_sel", int'(bus4.digit_sel), 1);
        check("mg_rel2_out", int'(bus4.digit_out), 1);
        step(4);
        check("mg_adv_idx", int'(bus4.digit_idx), 1);
        step(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
